combo_sender: RTL and testbench

Transmit-side companion to the keypad lock FSM. Accepts a combination word plus a start pulse and drives the keypad's ZBUT/OBUT inputs one bit per press, MSB first, with exactly one button high per press cycle. After the last press it watches the keypad's ULCK/RSTO/LOCK outputs and reports pass, fail or timeout. Used as an auto-dialer in system benches and as the programmable entry source on the board.

---
 rtl/combo_sender.sv | 221 ++++++++++++++++++++++
 tb/tb_combo_sender.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_sender.sv
// combo_sender: dials a keypad combination MSB-first on zbut/obut and reports pass/fail/timeout.
// Optional `COMBO_RETRY_EN: resend the code once after a first response timeout; adds output retried.
module combo_sender #(
   parameter int unsigned CODE_LEN     = 4,
   parameter int unsigned GAP_CYCLES   = 0,
   parameter int unsigned RESP_TIMEOUT = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [CODE_LEN-1:0] code,
   input  logic                ulck_in,
   input  logic                rsto_in,
   input  logic                lock_in,
   output logic                zbut,
   output logic                obut,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                fail,
   output logic                timeout
`ifdef COMBO_RETRY_EN
   ,
   output logic                retried
`endif
);

   localparam int unsigned MAX_GR     = (GAP_CYCLES > RESP_TIMEOUT) ? GAP_CYCLES : RESP_TIMEOUT;
   localparam int unsigned MAX_ALL    = (MAX_GR > CODE_LEN) ? MAX_GR : CODE_LEN;
   localparam int unsigned CNT_W      = (MAX_ALL > 0) ? $clog2(MAX_ALL + 1) : 1;
   localparam int unsigned GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int unsigned RESP_LAST  = (RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0;
   localparam int unsigned PRESS_LAST = (CODE_LEN > 0) ? CODE_LEN - 1 : 0;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PRESS  = 3'd1;
   localparam logic [2:0] S_GAP    = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_REPORT = 3'd4;

   localparam logic [1:0] R_NONE    = 2'd0;
   localparam logic [1:0] R_PASS    = 2'd1;
   localparam logic [1:0] R_FAIL    = 2'd2;
   localparam logic [1:0] R_TIMEOUT = 2'd3;

   logic [2:0]          state_q, state_d;
   logic [CODE_LEN-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                zbut_q, zbut_d;
   logic                obut_q, obut_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic                fail_q, fail_d;
   logic                timeout_q, timeout_d;
   logic [1:0]          res;
`ifdef COMBO_RETRY_EN
   logic [CODE_LEN-1:0] code_q, code_d;
   logic                retried_q, retried_d;
`endif

   // lock_in is status only and never steers the sequence
   logic unused_lock;
   assign unused_lock = lock_in;

   // next-state, counters and registered output values
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      timeout_d = timeout_q;
      res       = R_NONE;
`ifdef COMBO_RETRY_EN
      code_d    = code_q;
      retried_d = retried_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_PRESS;
               shift_d   = code;
               idx_d     = '0;
               cnt_d     = '0;
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               timeout_d = 1'b0;
`ifdef COMBO_RETRY_EN
               code_d    = code;
               retried_d = 1'b0;
`endif
            end
         end
         S_PRESS: begin
            if (rsto_in) begin
               state_d = S_REPORT;
               res     = R_FAIL;
            end else begin
               shift_d = shift_q << 1;
               cnt_d   = '0;
               if (idx_q == CNT_W'(PRESS_LAST)) begin
                  state_d = S_WAIT;
               end else begin
                  idx_d   = idx_q + CNT_W'(1);
                  state_d = (GAP_CYCLES > 0) ? S_GAP : S_PRESS;
               end
            end
         end
         S_GAP: begin
            if (rsto_in) begin
               state_d = S_REPORT;
               res     = R_FAIL;
            end else if (cnt_q == CNT_W'(GAP_LAST)) begin
               cnt_d   = '0;
               state_d = S_PRESS;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            // rsto wins over ulck when both arrive together
            if (rsto_in) begin
               state_d = S_REPORT;
               res     = R_FAIL;
            end else if (ulck_in) begin
               state_d = S_REPORT;
               res     = R_PASS;
            end else if (cnt_q == CNT_W'(RESP_LAST)) begin
`ifdef COMBO_RETRY_EN
               if (!retried_q) begin
                  state_d   = S_PRESS;
                  shift_d   = code_q;
                  idx_d     = '0;
                  cnt_d     = '0;
                  retried_d = 1'b1;
               end else begin
                  state_d = S_REPORT;
                  res     = R_TIMEOUT;
               end
`else
               state_d = S_REPORT;
               res     = R_TIMEOUT;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_REPORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (res)
         R_PASS:    pass_d    = 1'b1;
         R_FAIL:    fail_d    = 1'b1;
         R_TIMEOUT: timeout_d = 1'b1;
         default:   ;
      endcase

      // outputs follow the state being entered so they line up with it
      obut_d = (state_d == S_PRESS) &  shift_d[CODE_LEN-1];
      zbut_d = (state_d == S_PRESS) & ~shift_d[CODE_LEN-1];
      busy_d = (state_d == S_PRESS) || (state_d == S_GAP) || (state_d == S_WAIT);
      done_d = (state_d == S_REPORT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         zbut_q    <= 1'b0;
         obut_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
`ifdef COMBO_RETRY_EN
         code_q    <= '0;
         retried_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         zbut_q    <= zbut_d;
         obut_q    <= obut_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         timeout_q <= timeout_d;
`ifdef COMBO_RETRY_EN
         code_q    <= code_d;
         retried_q <= retried_d;
`endif
      end
   end

   assign zbut    = zbut_q;
   assign obut    = obut_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = pass_q;
   assign fail    = fail_q;
   assign timeout = timeout_q;
`ifdef COMBO_RETRY_EN
   assign retried = retried_q;
`endif

endmodule

// File: tb/tb_combo_sender.sv
// tb_combo_sender: randomized scoreboard bench; expected presses and results come from a timing model.
module tb_combo_sender;

   localparam int CL = 4;
   localparam int RT = 8;
   localparam int G0 = 0;
   localparam int G1 = 2;

   typedef struct { int cyc; logic bitv; } press_t;
   typedef struct { int cyc; logic pass_e; logic fail_e; logic tmo_e; logic retr_e; } res_t;

   logic clk, reset, start, ulck_in, rsto_in, lock_in;
   logic [CL-1:0] code;
   logic zbut, obut, busy, done, pass, fail, timeout;
   logic start_g;
   logic [CL-1:0] code_g;
   logic zbut_g, obut_g, busy_g, done_g, pass_g, fail_g, timeout_g;
`ifdef COMBO_RETRY_EN
   logic retried, retried_g;
`endif

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   press_t pq[$];
   res_t   rq[$];
   press_t gpq[$];
   res_t   grq[$];

   combo_sender #(.CODE_LEN(CL), .GAP_CYCLES(G0), .RESP_TIMEOUT(RT)) dut (
      .clk(clk), .reset(reset), .start(start), .code(code),
      .ulck_in(ulck_in), .rsto_in(rsto_in), .lock_in(lock_in),
      .zbut(zbut), .obut(obut), .busy(busy), .done(done),
      .pass(pass), .fail(fail), .timeout(timeout)
`ifdef COMBO_RETRY_EN
     ,.retried(retried)
`endif
   );

   combo_sender #(.CODE_LEN(CL), .GAP_CYCLES(G1), .RESP_TIMEOUT(RT)) dut_gap (
      .clk(clk), .reset(reset), .start(start_g), .code(code_g),
      .ulck_in(1'b0), .rsto_in(1'b0), .lock_in(lock_in),
      .zbut(zbut_g), .obut(obut_g), .busy(busy_g), .done(done_g),
      .pass(pass_g), .fail(fail_g), .timeout(timeout_g)
`ifdef COMBO_RETRY_EN
     ,.retried(retried_g)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // lock_in wanders freely; it must never influence results
   initial begin
      lock_in = 1'b0;
      forever begin
         @(posedge clk); #1;
         lock_in = 1'($urandom_range(0, 1));
      end
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void unexp(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endfunction

   // main-instance monitor
   always @(negedge clk) begin
      press_t e;
      res_t   r;
      if ((zbut === 1'b1) || (obut === 1'b1)) begin
         chk("one_button", 32'(zbut ^ obut), 1);
         if (pq.size() == 0) unexp("press");
         else begin
            e = pq.pop_front();
            chk("press_cycle", cyc, e.cyc);
            chk("press_bit", 32'(obut), 32'(e.bitv));
            chk("press_busy", 32'(busy), 1);
            chk("press_flags_clear", 32'(pass | fail | timeout), 0);
         end
      end
      if (done === 1'b1) begin
         if (rq.size() == 0) unexp("done");
         else begin
            r = rq.pop_front();
            chk("done_cycle", cyc, r.cyc);
            chk("done_pass", 32'(pass), 32'(r.pass_e));
            chk("done_fail", 32'(fail), 32'(r.fail_e));
            chk("done_timeout", 32'(timeout), 32'(r.tmo_e));
            chk("done_busy", 32'(busy), 0);
`ifdef COMBO_RETRY_EN
            chk("done_retried", 32'(retried), 32'(r.retr_e));
`endif
         end
      end
   end

   // gap-instance monitor
   always @(negedge clk) begin
      press_t e;
      res_t   r;
      if ((zbut_g === 1'b1) || (obut_g === 1'b1)) begin
         chk("gap_one_button", 32'(zbut_g ^ obut_g), 1);
         if (gpq.size() == 0) unexp("gap_press");
         else begin
            e = gpq.pop_front();
            chk("gap_press_cycle", cyc, e.cyc);
            chk("gap_press_bit", 32'(obut_g), 32'(e.bitv));
         end
      end
      if (done_g === 1'b1) begin
         if (grq.size() == 0) unexp("gap_done");
         else begin
            r = grq.pop_front();
            chk("gap_done_cycle", cyc, r.cyc);
            chk("gap_done_timeout", 32'(timeout_g), 32'(r.tmo_e));
            chk("gap_done_pass", 32'(pass_g), 32'(r.pass_e));
         end
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   // mode: 0 ulck after d, 1 rsto after d, 2 both after d, 3 silent, 4 rsto on press d, 5 ulck noise in presses then silent
   task automatic send(input logic [CL-1:0] c, input int mode, input int d, input bit spam);
      int n, last, t_done, rsto_cyc, ulck_cyc, npress, attempts, span;
      logic p, f, t, r;
      n        = cyc;
      span     = (CL - 1) * (G0 + 1) + 1 + RT;
      last     = n + 1 + (CL - 1) * (G0 + 1);
      rsto_cyc = -1;
      ulck_cyc = -1;
      npress   = CL;
      attempts = 1;
      p = 1'b0; f = 1'b0; t = 1'b0; r = 1'b0;
      case (mode)
         0: begin ulck_cyc = last + d; t_done = last + d + 1; p = 1'b1; end
         1: begin rsto_cyc = last + d; t_done = last + d + 1; f = 1'b1; end
         2: begin rsto_cyc = last + d; ulck_cyc = last + d; t_done = last + d + 1; f = 1'b1; end
         4: begin npress = d + 1; rsto_cyc = n + 1 + d * (G0 + 1); t_done = rsto_cyc + 1; f = 1'b1; end
         default: begin
            t = 1'b1;
            t_done = last + RT + 1;
`ifdef COMBO_RETRY_EN
            attempts = 2;
            r = 1'b1;
            t_done = t_done + span;
`endif
         end
      endcase
      for (int a = 0; a < attempts; a++)
         for (int k = 0; k < npress; k++)
            pq.push_back('{cyc: n + 1 + a * span + k * (G0 + 1), bitv: c[CL-1-k]});
      rq.push_back('{cyc: t_done, pass_e: p, fail_e: f, tmo_e: t, retr_e: r});
      start = 1'b1;
      code  = c;
      for (int cy = n + 1; cy <= t_done; cy++) begin
         @(posedge clk); #1;
         rsto_in = (cy == rsto_cyc);
         ulck_in = (cy == ulck_cyc) || (mode == 5 && cy <= last && $urandom_range(0, 1) == 1);
         start   = spam && ($urandom_range(0, 1) == 1);
         code    = CL'($urandom);
      end
      @(posedge clk); #1;
      start   = 1'b0;
      rsto_in = 1'b0;
      ulck_in = 1'b0;
      @(negedge clk);
      chk("sticky_pass", 32'(pass), 32'(p));
      chk("sticky_fail", 32'(fail), 32'(f));
      chk("sticky_timeout", 32'(timeout), 32'(t));
      chk("idle_busy", 32'(busy), 0);
   endtask

   task automatic send_gap(input logic [CL-1:0] c);
      int n, span, t_done, attempts;
      logic r;
      n        = cyc;
      span     = (CL - 1) * (G1 + 1) + 1 + RT;
      attempts = 1;
      r        = 1'b0;
`ifdef COMBO_RETRY_EN
      attempts = 2;
      r        = 1'b1;
`endif
      t_done = n + attempts * span + 1;
      for (int a = 0; a < attempts; a++)
         for (int k = 0; k < CL; k++)
            gpq.push_back('{cyc: n + 1 + a * span + k * (G1 + 1), bitv: c[CL-1-k]});
      grq.push_back('{cyc: t_done, pass_e: 1'b0, fail_e: 1'b0, tmo_e: 1'b1, retr_e: r});
      start_g = 1'b1;
      code_g  = c;
      @(posedge clk); #1;
      start_g = 1'b0;
      code_g  = ~c;
      wait_cyc(t_done + 1);
      @(negedge clk);
      chk("gap_sticky_timeout", 32'(timeout_g), 1);
      chk("gap_idle_busy", 32'(busy_g), 0);
   endtask

   task automatic reset_mid_send(input logic [CL-1:0] c);
      int n;
      n = cyc;
      pq.push_back('{cyc: n + 1, bitv: c[CL-1]});
      pq.push_back('{cyc: n + 2, bitv: c[CL-2]});
      start = 1'b1;
      code  = c;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_zbut", 32'(zbut), 0);
      chk("rst_obut", 32'(obut), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_flags", 32'({pass, fail, timeout}), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int mode, d;
      reset   = 1'b1;
      start   = 1'b0;
      code    = '0;
      rsto_in = 1'b0;
      ulck_in = 1'b0;
      start_g = 1'b0;
      code_g  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 32'({zbut, obut, busy, done, pass, fail, timeout}), 0);
      chk("reset_outputs_gap", 32'({zbut_g, obut_g, busy_g, done_g, pass_g, fail_g, timeout_g}), 0);
`ifdef COMBO_RETRY_EN
      chk("reset_retried", 32'({retried, retried_g}), 0);
`endif
      reset = 1'b0;
      @(posedge clk); #1;

      send_gap(4'b1000);
      send_gap(CL'($urandom));

      send(4'b1000, 0, 2, 1'b0);
      send(4'b1001, 1, 1, 1'b0);
      send(4'b1000, 3, 0, 1'b0);
      send(4'b0110, 2, 3, 1'b1);
      send(4'b1010, 4, 1, 1'b0);
      send(4'b0111, 4, CL - 1, 1'b0);
      send(4'b0101, 0, RT, 1'b0);
      send(4'b1100, 1, RT, 1'b1);
      send(4'b0011, 5, 0, 1'b1);

      reset_mid_send(4'b1011);
      send(4'b1011, 0, 3, 1'b0);

      for (int i = 0; i < 24; i++) begin
         mode = int'($urandom_range(0, 5));
         d    = (mode == 4) ? int'($urandom_range(0, CL - 1)) : int'($urandom_range(1, RT));
         send(CL'($urandom), mode, d, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (4) @(posedge clk);
      #1;
      chk("press_queue_drained", pq.size(), 0);
      chk("result_queue_drained", rq.size(), 0);
      chk("gap_press_queue_drained", gpq.size(), 0);
      chk("gap_result_queue_drained", grq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
